intra4_rd_select: RTL

- Downstream consumer of the 4x4 spectral-distortion stage in the intra-4x4 mode-decision path.
- For each 4x4 sub-block it accepts one candidate per prediction mode. Each candidate carries a TDisto result, an SSE, a rate and a header cost.
- It computes the RD score per candidate in a pipeline and keeps the running minimum.
- After NUM_MODES candidates it emits the best mode and its score fields.

---
 rtl/intra4_rd_select.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/intra4_rd_select.sv
// intra4_rd_select: RD-score evaluation and best-mode tracking for one 4x4
// sub-block of the intra-4x4 mode decision. One candidate per mode arrives
// from the spectral-distortion stage. Each candidate's score is computed in
// a two-stage pipeline and folded into a running minimum.
module intra4_rd_select #(
  parameter int unsigned NUM_MODES  = 10,
  parameter int unsigned DISTO_MULT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        tlambda,
  input  logic [15:0]        lambda,
  input  logic               cand_valid,
  input  logic [3:0]         cand_mode,
  input  logic signed [31:0] disto,
  input  logic [31:0]        sse,
  input  logic [31:0]        rate,
  input  logic [15:0]        hdr,
  output logic               busy,
  output logic               done,
  output logic [3:0]         best_mode,
  output logic [63:0]        best_score,
  output logic [31:0]        best_sd
);

  localparam int unsigned CW = $clog2(NUM_MODES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   tlambda_q, tlambda_d;
  logic [15:0]   lambda_q, lambda_d;

  // Stage 1: SD and the rate term
  logic          s1_valid_q, s1_valid_d;
  logic [3:0]    s1_mode_q, s1_mode_d;
  logic [31:0]   s1_sse_q, s1_sse_d;
  logic [31:0]   s1_sd_q, s1_sd_d;
  logic [63:0]   s1_rl_q, s1_rl_d;

  // Stage 2: full score
  logic          s2_valid_q, s2_valid_d;
  logic [3:0]    s2_mode_q, s2_mode_d;
  logic [31:0]   s2_sd_q, s2_sd_d;
  logic [63:0]   s2_score_q, s2_score_d;

  // Tracker. have_best stands in for the all-ones initial best score, so
  // the visible outputs hold their old values until a new candidate lands.
  logic          have_best_q, have_best_d;
  logic [3:0]    best_mode_q, best_mode_d;
  logic [63:0]   best_score_q, best_score_d;
  logic [31:0]   best_sd_q, best_sd_d;

  logic          accept;
  logic [31:0]   dc;
  logic [47:0]   sd_prod;

  // Datapath: clamp distortion, scale to SD, build score terms
  always_comb begin
    dc         = disto[31] ? '0 : $unsigned(disto);
    sd_prod    = 48'(tlambda_q) * 48'(dc);
    s1_mode_d  = cand_mode;
    s1_sse_d   = sse;
    s1_sd_d    = (tlambda_q == 16'd0) ? '0 : 32'((sd_prod + 48'd128) >> 8);
    s1_rl_d    = (64'(rate) + 64'(hdr)) * 64'(lambda_q);
    s2_mode_d  = s1_mode_q;
    s2_sd_d    = s1_sd_q;
    s2_score_d = s1_rl_q + 64'(DISTO_MULT) * (64'(s1_sse_q) + 64'(s1_sd_q));
  end

  // Control: FSM next state, candidate counting, pipeline valids, tracker
  always_comb begin
    accept       = cand_valid && (state_q == S_COLLECT) && !start;
    state_d      = state_q;
    cnt_d        = cnt_q;
    tlambda_d    = tlambda_q;
    lambda_d     = lambda_q;
    s1_valid_d   = accept;
    s2_valid_d   = s1_valid_q;
    have_best_d  = have_best_q;
    best_mode_d  = best_mode_q;
    best_score_d = best_score_q;
    best_sd_d    = best_sd_q;

    if (s2_valid_q && (!have_best_q || (s2_score_q < best_score_q))) begin
      have_best_d  = 1'b1;
      best_mode_d  = s2_mode_q;
      best_score_d = s2_score_q;
      best_sd_d    = s2_sd_q;
    end

    if (start) begin
      // start from any state restarts; in-flight work and tracker are dropped
      state_d     = S_COLLECT;
      cnt_d       = '0;
      tlambda_d   = tlambda;
      lambda_d    = lambda;
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      have_best_d = 1'b0;
      best_mode_d  = best_mode_q;
      best_score_d = best_score_q;
      best_sd_d    = best_sd_q;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (cand_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NUM_MODES - 1)) state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!s1_valid_q && !s2_valid_q) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tlambda_q    <= '0;
      lambda_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= '0;
      s1_sse_q     <= '0;
      s1_sd_q      <= '0;
      s1_rl_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_mode_q    <= '0;
      s2_sd_q      <= '0;
      s2_score_q   <= '0;
      have_best_q  <= 1'b0;
      best_mode_q  <= '0;
      best_score_q <= '0;
      best_sd_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tlambda_q    <= tlambda_d;
      lambda_q     <= lambda_d;
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_sse_q     <= s1_sse_d;
      s1_sd_q      <= s1_sd_d;
      s1_rl_q      <= s1_rl_d;
      s2_valid_q   <= s2_valid_d;
      s2_mode_q    <= s2_mode_d;
      s2_sd_q      <= s2_sd_d;
      s2_score_q   <= s2_score_d;
      have_best_q  <= have_best_d;
      best_mode_q  <= best_mode_d;
      best_score_q <= best_score_d;
      best_sd_q    <= best_sd_d;
    end
  end

  assign busy       = (state_q == S_COLLECT) || (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);
  assign best_mode  = best_mode_q;
  assign best_score = best_score_q;
  assign best_sd    = best_sd_q;

endmodule
